spike_rate_encoder: RTL

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/spike_rate_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns a table of per-synapse firing intensities into a
// stream of stochastic spike vectors (rate coding) for one neuron_lif.
// Each run produces exactly `steps` spike vectors (0 means 256). Bit i of a
// vector fires when a pseudo-random value drawn from a shared 16-bit LFSR is
// below intensity i.
module spike_rate_encoder #(
  parameter int SYNAPSES       = 32,
  parameter int INTENSITY_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [INTENSITY_BITS-1:0] load_data,
  input  logic                      start,
  input  logic [7:0]                steps,
  output logic                      busy,
  output logic [SYNAPSES-1:0]       spikes,
  output logic                      spikes_valid,
  output logic                      done
);

  localparam int          PTR_W     = $clog2(SYNAPSES);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    pointer;
  logic [7:0]          step_count;
  logic [15:0]         lfsr;
  logic [31:0]         lfsr_wide;
  logic                lfsr_feedback;
  logic                write_en;
  logic [SYNAPSES-1:0] spike_next;

  // The intensity table only accepts words while idle.
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign write_en   = load_valid && load_ready;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0.
  assign lfsr_feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Two copies back to back turn the mod-16 bit window into a plain part-select.
  assign lfsr_wide = {lfsr, lfsr};

  for (genvar g = 0; g < SYNAPSES; g++) begin : g_syn
    localparam int BASE = (g * INTENSITY_BITS) % 16;

    logic [INTENSITY_BITS-1:0] intensity;
    logic [INTENSITY_BITS-1:0] rand_val;

    // Intensity register for this synapse, written at the load pointer.
    always_ff @(posedge clk) begin
      // NOTE: the table is cleared on reset on purpose, so a run started
      // right after reset is fully deterministic (all intensities 0).
      if (reset) begin
        intensity <= '0;
      end else if (write_en && (pointer == PTR_W'(g))) begin
        intensity <= load_data;
      end
    end

    // Unsigned compare: intensity 0 can never fire, full scale almost always.
    assign rand_val      = lfsr_wide[BASE +: INTENSITY_BITS];
    assign spike_next[g] = (rand_val < intensity);
  end

  // Control FSM with registered spike/valid/done outputs.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values (spike_next sees the pre-advance LFSR).
    if (reset) begin
      state        <= IDLE;
      pointer      <= '0;
      step_count   <= '0;
      lfsr         <= LFSR_SEED;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spikes       <= '0;
          spikes_valid <= 1'b0;
          done         <= 1'b0;
          if (start) begin
            // A word offered alongside start is still written at the old
            // pointer (write_en above); the pointer reset wins here.
            step_count <= steps;
            pointer    <= '0;
            state      <= RUN;
          end else if (write_en) begin
            pointer <= pointer + PTR_W'(1);
          end
        end
        RUN: begin
          spikes       <= spike_next;
          spikes_valid <= 1'b1;
          lfsr         <= {lfsr[14:0], lfsr_feedback};
          // steps = 0 wraps to 255 here, giving 256 RUN cycles in total.
          step_count   <= step_count - 8'd1;
          if (step_count == 8'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          spikes       <= '0;
          spikes_valid <= 1'b0;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
